// File: rtl/fifo_ctrl_pkg.sv
// Shared types and FIFO geometry for the FIFO write-side arbiter.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int FIFO_DEPTH   = 64;
    localparam int FIFO_DATA_W  = 8;
    localparam int FIFO_COUNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority picker: first set bit of req_vec_i at or after start_i.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_vec_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_vec_i[(int'(start_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(start_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter owning the single write port of the shared FIFO.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ-1:0]          req_en,
    output logic [N_REQ-1:0]          gnt,
    input  logic                      fifo_full,
    input  logic [FIFO_COUNT_W-1:0]   fifo_count,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic                      ovf_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = FIFO_COUNT_W;

    arb_state_e          state_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [BW-1:0]       beat_cnt_q;
    logic                fifo_wr_q;
    logic [DATA_W-1:0]   fifo_data_q;
    logic                ovf_q;

    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic [CW:0]         occ_sum;
    logic                space_ok;
    logic                owner_req;
    logic                beat;
    logic                release_on_beat;
    logic [IW-1:0]       ptr_after_owner;
    logic [DATA_W-1:0]   owner_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_vec_i (req & req_en),
        .start_i   (rr_ptr_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    // The count lags our registered write by a cycle, so the in-flight write is reserved too.
    assign occ_sum   = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_wr_q};
    assign space_ok  = !fifo_full && (occ_sum < (CW+1)'(DEPTH));
    assign owner_req = req[owner_q] && req_en[owner_q];
    assign beat      = (state_q == BURST) && owner_req && space_ok;
    assign owner_data = req_data[int'(owner_q)*DATA_W +: DATA_W];

    assign release_on_beat = req_last[owner_q] || (beat_cnt_q == BW'(MAX_BURST - 1));
    assign ptr_after_owner = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

    always_comb begin
        gnt = '0;
        if (beat) gnt[owner_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (fifo_wr_q && fifo_full) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    fifo_wr_q <= 1'b0;
                    if (pick_valid) begin
                        owner_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req) begin
                        fifo_wr_q <= 1'b0;
                        rr_ptr_q  <= ptr_after_owner;
                        state_q   <= IDLE;
                    end else if (beat) begin
                        fifo_wr_q   <= 1'b1;
                        fifo_data_q <= owner_data;
                        beat_cnt_q  <= beat_cnt_q + BW'(1);
                        if (release_on_beat) begin
                            rr_ptr_q <= ptr_after_owner;
                            state_q  <= IDLE;
                        end
                    end else begin
                        // Stalled on space: keep ownership, issue nothing.
                        fifo_wr_q <= 1'b0;
                    end
                end
                default: begin
                    fifo_wr_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign fifo_wr      = fifo_wr_q;
    assign fifo_data_in = fifo_data_q;
    assign owner        = owner_q;
    assign busy         = (state_q == BURST);
    assign ovf_err      = ovf_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin, burst-aware write arbiter that shares the single write port of the 64-entry, 8-bit FIFO between N_REQ producers.
- Owns fifo_wr/fifo_data_in exclusively.
- Uses the FIFO's full/count outputs plus its own in-flight write to guarantee the FIFO is never written while full.
- Sits directly in front of the FIFO; consumers keep using the FIFO read side unchanged.

Parameters:
N_REQ, 4, number of producers (2..8)
DATA_W, 8, data width; matches FIFO data_in
DEPTH, 64, FIFO capacity in entries
MAX_BURST, 8, maximum beats granted to one owner per tenure (1..16)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  per-producer beat valid
req_data  in  N_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
req_last  in  N_REQ  final beat of producer's packet
req_en  in  N_REQ  eligibility mask; 0 removes producer from arbitration
gnt  out  N_REQ  beat accepted this cycle (combinational, onehot0)
fifo_full  in  1  FIFO full flag
fifo_count  in  16  FIFO occupancy
fifo_wr  out  1  registered FIFO write strobe
fifo_data_in  out  DATA_W  registered FIFO write data
owner  out  $clog2(N_REQ)  current/last owner index
busy  out  1  state == BURST
ovf_err  out  1  sticky: fifo_wr asserted while fifo_full

Behaviour:
- Reset (reset == 0, async): every register is cleared.
  - state = IDLE, owner = 0, rr_ptr = 0, beat_cnt = 0.
  - fifo_wr = 0, fifo_data_in = 0, ovf_err = 0, so gnt = 0 and busy = 0.
  - An in-flight fifo_wr is dropped.
  - Reset mid-burst aborts the burst; no partial state survives.
- FSM states: IDLE, BURST.
- IDLE:
  - eligible = req & req_en.
  - If eligible != 0: owner <= first set bit of eligible, searching circularly from rr_ptr. beat_cnt <= 0. Go to BURST.
  - No gnt is issued in IDLE, so the minimum latency from req to first gnt is 1 cycle.
- BURST:
  - space_ok = !fifo_full && (fifo_count + fifo_wr) < DEPTH.
  - Compute the sum at 17 bits. fifo_wr is added because the count lags the registered write by one cycle.
  - gnt[owner] = req[owner] && req_en[owner] && space_ok. All other gnt bits are 0.
  - On a beat (any gnt bit set): fifo_wr <= 1, fifo_data_in <= req_data[owner], beat_cnt <= beat_cnt + 1. Otherwise fifo_wr <= 0 and fifo_data_in holds.
- BURST -> IDLE (rr_ptr <= owner + 1 mod N_REQ) when any of:
  - a beat with req_last[owner];
  - a beat where beat_cnt + 1 == MAX_BURST;
  - req[owner] == 0;
  - req_en[owner] == 0.
- Release costs exactly one IDLE cycle.
- A stall due to !space_ok keeps BURST with no beat and does not release.
- Write latency: data accepted on the gnt cycle appears on fifo_wr/fifo_data_in the next cycle. The FIFO captures it one edge later.
- Full boundary:
  - With fifo_count = 63 and fifo_wr = 1, space_ok = 0.
  - The FIFO therefore never receives more than DEPTH entries.
  - Simultaneous FIFO reads are ignored conservatively; space reappears on a later cycle.
- ovf_err sets on any cycle where fifo_wr && fifo_full and holds until reset. A correct design never sets it.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps modulo N_REQ; with non-power-of-2 N_REQ, it is explicitly reset to 0 after N_REQ-1.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - state enum arb_state_e {IDLE, BURST};
  - FIFO_DEPTH = 64;
  - FIFO_DATA_W = 8;
  - FIFO_COUNT_W = 16.
- One sub-module, rr_pick:
  - combinational circular priority picker;
  - inputs: N_REQ request vector and start pointer;
  - outputs: index and valid.
  - It is instantiated once in IDLE selection.

Test Plan:
- Single producer 0 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd) into an empty FIFO -> gnt[0] on 3 consecutive cycles starting 1 cycle after req. fifo_wr pulses 3 cycles, one cycle later. FIFO count = 3; busy drops after the last beat.
- Producers 0–3 all request continuously, with last on every beat -> owners rotate 0,1,2,3,0,…. Each grant is followed by one IDLE cycle; no producer is granted twice before the others.
- Producer 2 holds req with no last and MAX_BURST = 8 -> exactly 8 beats, then release. With producer 3 also requesting, the next owner is 3.
- FIFO pre-filled to count 62; producer 1 streams 5 beats -> exactly 2 writes accepted, then gnt stays 0 with busy = 1. After the FIFO reads 3 entries, the remaining 3 beats complete. Final count = 64, ovf_err = 0.
- req_en[1] cleared mid-burst at beat 2 -> gnt[1] = 0 that cycle, return to IDLE, next owner chosen from the remaining requesters.
- reset asserted mid-burst while fifo_wr = 1 -> immediately (async) fifo_wr = 0, gnt = 0, busy = 0, owner = 0. After release, arbitration restarts from producer 0.
